// File: rtl/ram_burst_reader_pkg.sv
// Shared definitions for the RAM burst reader: default widths, RAM depth,
// FSM state type and the burst-length clamp helper.
package ram_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;
    localparam int RAM_DEPTH  = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A burst can never cover more than the whole RAM once.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
        return (len > depth) ? depth : len;
    endfunction

endpackage

// File: rtl/ram_burst_reader_if.sv
// Control, RAM and stream signals of the burst reader. Defining
// RAM_BURST_READER_CHECKSUM_EN adds the running checksum output.
interface ram_burst_reader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic              ram_cs;
    logic              ram_wr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dout;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
`ifdef RAM_BURST_READER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;

    modport master (
        input  start, start_addr, len, ram_dout, out_ready,
        output busy, done, ram_cs, ram_wr, ram_addr, out_data, out_valid, out_last, checksum
    );
    modport slave (
        output start, start_addr, len, ram_dout, out_ready,
        input  busy, done, ram_cs, ram_wr, ram_addr, out_data, out_valid, out_last, checksum
    );
`else
    modport master (
        input  start, start_addr, len, ram_dout, out_ready,
        output busy, done, ram_cs, ram_wr, ram_addr, out_data, out_valid, out_last
    );
    modport slave (
        output start, start_addr, len, ram_dout, out_ready,
        input  busy, done, ram_cs, ram_wr, ram_addr, out_data, out_valid, out_last
    );
`endif
endinterface

// File: rtl/ram_burst_reader_fifo.sv
// Two-entry output buffer between the RAM read pipeline and the stream port.
module rd_fifo2 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [1:0]        o_count
);
    logic [DATA_W-1:0] r_mem [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;
    logic              w_push;
    logic              w_pop;

    // A push into a full buffer is only legal when the head leaves the same cycle.
    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/ram_burst_reader.sv
// Burst reader: streams len bytes from a 1-cycle-latency RAM starting at
// start_addr. RAM_BURST_READER_CHECKSUM_EN enables the per-burst checksum.
module ram_burst_reader
    import ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input logic               clk,
    input logic               rst_n,
    ram_burst_reader_if.master bus
);
    localparam int CNT_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_iss_rem;
    logic [CNT_W-1:0]  r_out_rem;
    logic              r_busy;
    logic              r_done;
    logic              r_rd_pend;

    logic              w_issue;
    logic              w_xfer;
    logic              w_full;
    logic              w_empty;
    logic [1:0]        w_count;
    logic [2:0]        w_occ;
    logic [DATA_W-1:0] w_head;
    logic [CNT_W-1:0]  w_len_clamped;

    assign w_len_clamped = CNT_W'(clamp_len(32'(bus.len), DEPTH));
    assign w_xfer        = !w_empty && bus.out_ready;

    // Occupancy after this cycle's transfer: buffered bytes plus the read whose
    // data is on ram_dout now. Counting the departing byte keeps one byte per cycle.
    assign w_occ   = 3'(w_count) - 3'(w_xfer) + 3'(r_rd_pend);
    assign w_issue = (r_state == RUN) && (r_iss_rem != '0) && (w_occ < 3'd2)
                     && !(w_full && !w_xfer);

    rd_fifo2 #(.DATA_W(DATA_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_rd_pend),
        .i_pop   (w_xfer),
        .i_data  (bus.ram_dout),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_iss_rem <= '0;
            r_out_rem <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_pend <= 1'b0;
        end else begin
            r_rd_pend <= w_issue;
            r_done    <= 1'b0;
            if (w_issue) begin
                r_addr    <= r_addr + ADDR_W'(1);
                r_iss_rem <= r_iss_rem - CNT_W'(1);
            end
            if (w_xfer) begin
                r_out_rem <= r_out_rem - CNT_W'(1);
            end
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_addr    <= bus.start_addr;
                        r_iss_rem <= w_len_clamped;
                        r_out_rem <= w_len_clamped;
                        r_busy    <= 1'b1;
                        if (w_len_clamped == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (w_issue && (r_iss_rem == CNT_W'(1))) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_xfer && (r_out_rem == CNT_W'(1))) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef RAM_BURST_READER_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if ((r_state == IDLE) && bus.start) begin
            r_checksum <= '0;
        end else if (w_xfer) begin
            r_checksum <= r_checksum + w_head;
        end
    end

    assign bus.checksum = r_checksum;
`endif

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.ram_cs    = w_issue;
    assign bus.ram_wr    = 1'b0;
    assign bus.ram_addr  = r_addr;
    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_empty ? '0 : w_head;
    assign bus.out_last  = !w_empty && (r_out_rem == CNT_W'(1));

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a queue-based reference model
// checked every cycle, plus literal expectations per scenario.
module tb_ram_burst_reader;
    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 1024;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_burst_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_burst_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // RAM model: mem[a] = 2a mod 256, data one cycle after the chip-select cycle
    logic [DW-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'((2 * i) % 256);
    end
    always @(posedge clk) begin
        if (bus.ram_cs) bus.ram_dout <= mem[bus.ram_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got event expected none", nm);
    endtask

    // Reference model state
    int            cyc = 0;
    logic [7:0]    expq[$];
    int            addrq[$];
    int            outstanding = 0;
    bit            exp_active = 0;
    bit            exp_done_now = 0;
    bit            prev_valid = 0, prev_ready = 0, prev_last = 0;
    logic [7:0]    prev_data = 0;
    int            accept_cyc = 0;
    bit            first_cs_seen = 1, first_valid_seen = 1, ready_all = 0;
    logic [7:0]    got_bytes[$];
    int            got_addrs[$];
    int            cs_count = 0;

    function automatic int clampl(input int l);
        return (l > DEPTH) ? DEPTH : l;
    endfunction

    always @(negedge clk) begin
        bit         xfer, accept, done_next;
        int         n, a0;
        logic [7:0] e;
        cyc++;
        if (!rst_n) begin
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_ram_cs", bus.ram_cs, 0);
            chk("rst_ram_wr", bus.ram_wr, 0);
            chk("rst_ram_addr", bus.ram_addr, 0);
            chk("rst_out_data", bus.out_data, 0);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_out_last", bus.out_last, 0);
            expq.delete();
            addrq.delete();
            outstanding  = 0;
            exp_active   = 0;
            exp_done_now = 0;
            prev_valid   = 0;
        end else begin
            xfer      = bus.out_valid && bus.out_ready;
            accept    = bus.start && !exp_active;
            done_next = 0;
            chk("done", bus.done, exp_done_now);
            chk("busy", bus.busy, exp_active);
            chk("ram_wr", bus.ram_wr, 0);
            if (bus.ram_cs) begin
                cs_count++;
                got_addrs.push_back(int'(bus.ram_addr));
                if (addrq.size() == 0) fail_now("spurious_read");
                else chk("ram_addr", bus.ram_addr, addrq.pop_front());
                chk("occupancy_lt2", ((outstanding - int'(xfer)) < 2) ? 1 : 0, 1);
                if (!first_cs_seen) begin
                    chk("lat_first_cs", cyc - accept_cyc, 1);
                    first_cs_seen = 1;
                end
                outstanding++;
            end
            if (bus.out_valid && !first_valid_seen) begin
                chk("lat_first_valid", cyc - accept_cyc, 3);
                first_valid_seen = 1;
            end
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", bus.out_data, prev_data);
                chk("hold_last", bus.out_last, prev_last);
            end
            if (exp_active && !bus.out_ready) ready_all = 0;
            if (exp_active && ready_all && first_valid_seen && expq.size() > 0)
                chk("throughput", bus.out_valid, 1);
            if (xfer) begin
                got_bytes.push_back(bus.out_data);
                if (expq.size() == 0) fail_now("extra_byte");
                else begin
                    e = expq.pop_front();
                    chk("out_data", bus.out_data, e);
                    chk("out_last", bus.out_last, (expq.size() == 0) ? 1 : 0);
                    if (expq.size() == 0) done_next = 1;
                end
                outstanding--;
            end
            if (accept) begin
                n  = clampl(int'(bus.len));
                a0 = int'(bus.start_addr);
                for (int i = 0; i < n; i++) begin
                    addrq.push_back((a0 + i) % DEPTH);
                    expq.push_back(8'((2 * ((a0 + i) % DEPTH)) % 256));
                end
                if (n == 0) done_next = 1;
                accept_cyc       = cyc;
                first_cs_seen    = (n == 0);
                first_valid_seen = (n == 0);
                ready_all        = 1;
                exp_active       = 1;
            end else if (exp_done_now) begin
                exp_active = 0;
            end
            exp_done_now = done_next;
            prev_valid   = bus.out_valid;
            prev_ready   = bus.out_ready;
            prev_data    = bus.out_data;
            prev_last    = bus.out_last;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input int addr, input int l);
        got_bytes.delete();
        got_addrs.delete();
        cs_count       = 0;
        bus.start      = 1'b1;
        bus.start_addr = AW'(addr);
        bus.len        = (AW + 1)'(l);
        tick(1);
        bus.start      = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (exp_active && k < budget) begin
            tick(1);
            k++;
        end
        if (exp_active) fail_now("timeout_burst");
    endtask

    task automatic chk_seq(input string nm, input int e[$]);
        chk({nm, "_count"}, got_bytes.size(), e.size());
        for (int i = 0; i < e.size() && i < got_bytes.size(); i++)
            chk(nm, got_bytes[i], e[i]);
    endtask

    initial begin
        int e[$];
        int k;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.len        = '0;
        bus.out_ready  = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Basic burst from address 0
        start_burst(0, 4);
        wait_idle(40);
        e = '{0, 2, 4, 6};
        chk_seq("b0_bytes", e);
`ifdef RAM_BURST_READER_CHECKSUM_EN
        chk("b0_checksum", bus.checksum, 12);
`endif
        $display("[TB] burst addr=0 len=4 bytes=%0d", got_bytes.size());

        // Address wrap at the top of the RAM
        start_burst(1022, 4);
        wait_idle(40);
        e = '{1022, 1023, 0, 1};
        chk("wrap_addr_count", got_addrs.size(), 4);
        for (int i = 0; i < 4 && i < got_addrs.size(); i++) chk("wrap_addr", got_addrs[i], e[i]);
        e = '{252, 254, 0, 2};
        chk_seq("wrap_bytes", e);
        $display("[TB] burst addr=1022 len=4 bytes=%0d", got_bytes.size());

        // Consumer stall after the second byte
        start_burst(10, 8);
        k = 0;
        while (got_bytes.size() < 2 && k < 40) begin
            tick(1);
            k++;
        end
        if (got_bytes.size() < 2) fail_now("timeout_stall_wait");
        bus.out_ready = 1'b0;
        tick(5);
        bus.out_ready = 1'b1;
        wait_idle(60);
        e = '{20, 22, 24, 26, 28, 30, 32, 34};
        chk_seq("stall_bytes", e);
        $display("[TB] burst addr=10 len=8 stalled bytes=%0d", got_bytes.size());

        // Irregular ready pattern
        start_burst(500, 6);
        for (int i = 0; i < 12; i++) begin
            bus.out_ready = (i % 3 != 0);
            tick(1);
        end
        bus.out_ready = 1'b1;
        wait_idle(60);
        e = '{232, 234, 236, 238, 240, 242};
        chk_seq("toggle_bytes", e);
        $display("[TB] burst addr=500 len=6 toggled bytes=%0d", got_bytes.size());

        // Empty burst: done one cycle after start, no reads
        start_burst(7, 0);
        chk("len0_done", bus.done, 1);
        wait_idle(10);
        chk("len0_cs", cs_count, 0);
        chk("len0_bytes", got_bytes.size(), 0);
        $display("[TB] burst addr=7 len=0 reads=%0d", cs_count);

        // Oversized length clamps to the RAM depth
        start_burst(100, 2000);
        wait_idle(1200);
        chk("clamp_bytes", got_bytes.size(), 1024);
        chk("clamp_reads", cs_count, 1024);
        if (got_bytes.size() == 1024) begin
            chk("clamp_first", got_bytes[0], 200);
            chk("clamp_lastb", got_bytes[1023], 198);
        end
        $display("[TB] burst addr=100 len=2000 bytes=%0d", got_bytes.size());

`ifdef RAM_BURST_READER_CHECKSUM_EN
        start_burst(0, 256);
        wait_idle(400);
        chk("cs256_checksum", bus.checksum, 0);
        $display("[TB] burst addr=0 len=256 checksum=%0d", bus.checksum);
`endif

        // Reset in the middle of a burst, then a clean short burst
        start_burst(0, 16);
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", bus.out_valid, 0);
        chk("midrst_busy", bus.busy, 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        start_burst(5, 2);
        wait_idle(40);
        e = '{10, 12};
        chk_seq("postrst_bytes", e);
        $display("[TB] burst addr=5 len=2 after reset bytes=%0d", got_bytes.size());

        tick(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        fail_now("global_timeout");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_burst_reader.md
RAM_BURST_READER -- requirements
Module: ram_burst_reader

Interface
- REQ-001 Parameter ADDR_W, default 10, RAM address width (1024 locations).
- REQ-002 Parameter DATA_W, default 8, RAM data width.
- REQ-003 clk  input  1  single clock; all state updates on rising edge.
- REQ-004 rst_n  input  1  asynchronous, active-low reset.
- REQ-005 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
- REQ-006 start_addr  input  ADDR_W  first RAM address of the burst.
- REQ-007 len  input  ADDR_W+1  burst length in bytes; 0 = empty burst; values >1024 clamp to 1024.
- REQ-008 busy  output  1  high in every state except IDLE.
- REQ-009 done  output  1  one-cycle pulse at burst completion.
- REQ-010 ram_cs  output  1  RAM chip select, active-high, one read per high cycle.
- REQ-011 ram_wr  output  1  RAM write enable; tied 0 (read-only initiator).
- REQ-012 ram_addr  output  ADDR_W  RAM address, valid when ram_cs=1.
- REQ-013 ram_dout  input  DATA_W  RAM read data, valid exactly 1 cycle after the ram_cs cycle.
- REQ-014 out_data  output  DATA_W  streamed byte.
- REQ-015 out_valid  output  1  out_data valid.
- REQ-016 out_ready  input  1  consumer accepts; transfer when out_valid & out_ready.
- REQ-017 out_last  output  1  high with the final byte of the burst.

Function
- REQ-018 FSM states SHALL be IDLE, RUN, DRAIN, DONE; IDLE->RUN on start with len!=0; IDLE->DONE on start with len==0; RUN->DRAIN after last read issued; DRAIN->DONE when final byte transfers; DONE->IDLE unconditionally.
- REQ-019 start while busy SHALL be ignored; start_addr/len latched only on an accepted start.
- REQ-020 Reads SHALL be issued only when (buffered + in-flight) < 2 and remaining > 0; at most one read per cycle.
- REQ-021 Address SHALL increment by 1 per issued read, wrapping 1023->0.
- REQ-022 Latency: start accepted at edge T -> first ram_cs high in cycle T+1 -> out_valid high from cycle T+3.
- REQ-023 With out_ready held 1, sustained throughput SHALL be one byte per cycle.
- REQ-024 out_data/out_valid/out_last SHALL hold stable while out_valid=1 and out_ready=0.
- REQ-025 Bytes SHALL be delivered in address order, none dropped or duplicated.
- REQ-026 done SHALL pulse in the cycle after the out_last transfer (DONE state), or the cycle after an accepted len==0 start.

Reset
- REQ-027 rst_n low SHALL immediately force IDLE, empty buffer, zero in-flight count, and all outputs (busy, done, ram_cs, ram_wr, ram_addr, out_data, out_valid, out_last) to 0.
- REQ-028 Reset mid-burst SHALL abort it; no residual byte appears after release.

Configuration
- REQ-029 Macro RAM_BURST_READER_CHECKSUM_EN defined: output checksum[DATA_W-1:0] = mod-256 sum of all transferred bytes of the current burst, cleared on accepted start, stable from done until next start.
- REQ-030 Macro undefined: checksum port and logic absent; all other behaviour identical.

Structure
- REQ-031 Shared package ram_pkg SHALL hold ADDR_W/DATA_W defaults, RAM_DEPTH=1024, and the FSM state typedef.
- REQ-032 The 2-entry output buffer SHALL be a sub-module rd_fifo2 (push, pop, data, full, empty, count).

Verification (RAM model preloaded mem[a]=(2*a)%256, 1-cycle read latency)
- REQ-033 start_addr=0, len=4, out_ready=1 -> bytes 0,2,4,6 on consecutive cycles, out_last with 6, done next cycle, ram_wr never 1.
- REQ-034 start_addr=1022, len=4 -> ram_addr 1022,1023,0,1; bytes 252,254,0,2.
- REQ-035 start_addr=10, len=8, out_ready low 5 cycles after byte 2 -> ram_cs low while buffer+in-flight=2, bytes 20..34 step 2 intact and ordered.
- REQ-036 len=0 -> done pulse one cycle after start, ram_cs never high; len=2000 -> exactly 1024 bytes.
- REQ-037 rst_n low in cycle 3 of a len=16 burst -> all outputs 0 during reset; following start_addr=5,len=2 yields 10,12 only.
- REQ-038 RAM_BURST_READER_CHECKSUM_EN defined, start_addr=0, len=4 -> checksum=12 at done; len=256 from 0 -> checksum=0.
